// File: rtl/ddram_pkg.sv
// ddram_pkg: shared DDR3 port widths and copy-engine state encoding
package ddram_pkg;
   localparam int DDR_ADDR_W = 29;
   localparam int DDR_DATA_W = 64;
   localparam int DDR_BE_W = 8;
   typedef enum logic [2:0] {CE_IDLE, CE_RD_REQ, CE_RD_DATA, CE_WR_REQ, CE_FIN} copy_state_e;
endpackage

// File: rtl/ddram_copy_buf.sv
// ddram_copy_buf: chunk buffer, registered write port and combinational read port
module ddram_copy_buf
   import ddram_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DDR_DATA_W-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DDR_DATA_W-1:0] rdata
);
   logic [DDR_DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/ddram_copy_engine.sv
// ddram_copy_engine: DDR3 block copy, burst-read chunks into a buffer then single-word writes
module ddram_copy_engine
   import ddram_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int LEN_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DDR_ADDR_W-1:0] src_addr,
   input  logic [DDR_ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]      len,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [LEN_W-1:0]      words_done,
   output logic [DDR_ADDR_W-1:0] rd_addr,
   output logic [7:0]            rd_burstcnt,
   output logic                  rd_req,
   input  logic                  rd_ack,
   input  logic [DDR_DATA_W-1:0] rd_data,
   input  logic                  rd_data_valid,
   output logic [DDR_ADDR_W-1:0] wr_addr,
   output logic [7:0]            wr_burstcnt,
   output logic [DDR_DATA_W-1:0] wr_data,
   output logic [DDR_BE_W-1:0]   wr_be,
   output logic                  wr_req,
   input  logic                  wr_ack,
   input  logic                  wr_busy
);
   localparam int IW = $clog2(MAX_BURST);
   copy_state_e state, state_nx;
   logic [DDR_ADDR_W-1:0] src, dst;
   logic [LEN_W-1:0] rem, n;
   logic [IW-1:0] idx;
   logic [DDR_DATA_W-1:0] buf_q;
   logic wr_act, last_at, rd_beat, last_beat, wr_hs, last_wr, job_end, abort_exit;

   assign n = (rem < LEN_W'(MAX_BURST)) ? rem : LEN_W'(MAX_BURST);
   assign last_at = LEN_W'(idx) == n - LEN_W'(1);
   // a beat riding on the rd_ack cycle is beat 0
   assign rd_beat = rd_data_valid & (((state == CE_RD_REQ) & rd_ack) | (state == CE_RD_DATA));
   assign last_beat = rd_beat & last_at;
   assign wr_hs = wr_req & wr_ack;
   assign last_wr = wr_hs & last_at;
   assign job_end = last_wr & (rem == n);
   assign abort_exit = abort & (((state == CE_IDLE) & start & (len != '0)) |
                                ((state == CE_WR_REQ) & (~wr_act | (last_wr & ~job_end))));

   ddram_copy_buf #(.DEPTH(MAX_BURST)) u_buf (
      .clk  (clk),
      .we   (rd_beat),
      .waddr(idx),
      .wdata(rd_data),
      .raddr(idx),
      .rdata(buf_q)
   );

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= CE_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         CE_IDLE:    state_nx = !start ? CE_IDLE : (len == '0 || abort) ? CE_FIN : CE_RD_REQ;
         CE_RD_REQ:  state_nx = last_beat ? CE_WR_REQ : rd_ack ? CE_RD_DATA : CE_RD_REQ;
         CE_RD_DATA: state_nx = last_beat ? CE_WR_REQ : CE_RD_DATA;
         CE_WR_REQ:  state_nx = (job_end || abort_exit) ? CE_FIN : last_wr ? CE_RD_REQ : CE_WR_REQ;
         default:    state_nx = CE_IDLE;
      endcase
   end

   // a fresh write only launches while the arbiter is free; a held one ignores wr_busy
   always_comb begin
      busy = state inside {CE_RD_REQ, CE_RD_DATA, CE_WR_REQ};
      done = state == CE_FIN;
      rd_req = state == CE_RD_REQ;
      rd_addr = src;
      rd_burstcnt = rd_req ? 8'(n) : '0;
      wr_req = (state == CE_WR_REQ) & (wr_act | (~wr_busy & ~abort));
      wr_addr = dst + DDR_ADDR_W'(idx);
      wr_data = (state == CE_WR_REQ) ? buf_q : '0;
      wr_be = (state == CE_WR_REQ) ? '1 : '0;
      wr_burstcnt = (state == CE_WR_REQ) ? 8'd1 : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src <= '0;
         dst <= '0;
         rem <= '0;
         idx <= '0;
         wr_act <= 1'b0;
         aborted <= 1'b0;
         words_done <= '0;
      end else begin
         wr_act <= wr_req & ~wr_ack;
         if (state == CE_IDLE && start) begin
            src <= src_addr;
            dst <= dst_addr;
            rem <= len;
            idx <= '0;
            words_done <= '0;
            aborted <= abort_exit;
         end else if (abort_exit) aborted <= 1'b1;
         if (rd_beat) idx <= last_beat ? '0 : idx + IW'(1);
         if (wr_hs) begin
            words_done <= words_done + LEN_W'(1);
            idx <= last_wr ? '0 : idx + IW'(1);
         end
         if (last_wr) begin
            src <= src + DDR_ADDR_W'(n);
            dst <= dst + DDR_ADDR_W'(n);
            rem <= rem - n;
         end
      end
   end
endmodule

// File: doc/ddram_copy_engine.md
# ddram_copy_engine

DDR3 block-copy sequencer that moves a contiguous run of 64-bit words from a source to a destination word address in DDR3. It occupies one requestor slot of the DDR3 arbiter, using the same rd/wr handshake as the other requestors. Each chunk is read as one burst of up to `MAX_BURST` words into a local buffer, then written back as single-word writes. The coordinator uses it for frame and texture moves without stalling the cores.

## Interface
- `MAX_BURST`, 8, largest read burst per chunk and local buffer depth in words; power of two, 2..128.
- `LEN_W`, 16, width of the transfer length in words.
- `clk` input 1: single clock for all logic.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle command strobe, sampled only in IDLE.
- `src_addr` input 29: source word address, captured on `start`.
- `dst_addr` input 29: destination word address, captured on `start`.
- `len` input LEN_W: word count, captured on `start`.
- `abort` input 1: level; stops the job at the next safe point.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse at job end.
- `aborted` output 1: valid with `done`, held until the next `start`.
- `words_done` output LEN_W: count of words written, cleared on `start`.
- `rd_addr` output 29, `rd_burstcnt` output 8, `rd_req` output 1: read request to the arbiter port.
- `rd_ack` input 1, `rd_data` input 64, `rd_data_valid` input 1: read response.
- `wr_addr` output 29, `wr_burstcnt` output 8, `wr_data` output 64, `wr_be` output 8, `wr_req` output 1: write request.
- `wr_ack` input 1, `wr_busy` input 1: write response.

## Operation
- States:
  - IDLE: wait for `start`.
  - RD_REQ: `rd_req` high, waiting for `rd_ack`.
  - RD_DATA: collecting burst beats.
  - WR_REQ: `wr_req` high, waiting for `wr_ack`.
  - FIN: one cycle, `done` high.
- IDLE + `start`:
  - If `len==0`, go to FIN with no bus traffic.
  - Otherwise latch `src_addr`, `dst_addr` and remaining = `len`, and go to RD_REQ.
- Chunk size n = min(remaining, MAX_BURST). `rd_burstcnt` = n and `rd_addr` = current source address, both held stable while `rd_req` is high.
- `rd_req` stays high until `rd_ack`. It deasserts in the cycle after `rd_ack` is sampled.
- If `rd_data_valid` is high in the same cycle as `rd_ack`, that beat counts as beat 0.
- Beats are written into the buffer at index 0..n-1. After beat n-1, go to WR_REQ.
- WR_REQ issues n single-word writes:
  - `wr_burstcnt` = 1 and `wr_be` = 8'hFF.
  - `wr_addr` = destination address + index; `wr_data` = buffer[index].
  - `wr_req` rises only in a cycle where `wr_busy` is low. Once high, it is held with stable address and data until `wr_ack`; `wr_busy` is ignored while held.
  - Each `wr_ack` increments index and `words_done`.
- After write n-1: source address, destination address and remaining all advance by n. If remaining is then 0 go to FIN, else go to RD_REQ.
- Addresses wrap modulo 2^29 with no error.
- `abort`:
  - Never cancels a request in flight, because the arbiter keeps the grant until the transaction completes.
  - An outstanding read completes all n beats, and an outstanding write waits for its ack.
  - `abort` is checked before each new `rd_req` and before each new `wr_req`. If set, go to FIN with `aborted` = 1.
  - Buffered words that were not yet written are discarded.
- `start` while busy is ignored. `rd_data_valid` outside RD_DATA (and outside the `rd_ack` cycle) is ignored.
- Assertion of `reset_n` (low) mid-job:
  - Immediately forces IDLE and drops `rd_req`/`wr_req`.
  - The system resets the arbiter at the same time, via its soft reset.

## Timing
- Reset values: all outputs 0, including `busy`, `done`, `aborted`, `words_done`, `rd_req`, `wr_req`, all address, count and data outputs, and `wr_be`.
- `start` at cycle t:
  - `busy` = 1 and `rd_req` = 1 at t+1 (`len` > 0).
  - `done` at t+1 when `len` = 0.
- Read data is registered into the buffer on its valid beat. The first `wr_req` can rise in the cycle after the last beat.
- Back-to-back writes: the next `wr_req` can be high in the cycle after `wr_ack`, giving a 2-cycle minimum per word.
- `done` pulses the cycle after the final `wr_ack`. `busy` falls in that same cycle.
- Best-case job cycles ≈ 1 + Σchunks(read latency + n + 2n) + 1.

## Structure
- Shared package `ddram_pkg`: `DDR_ADDR_W` = 29, `DDR_DATA_W` = 64, `DDR_BE_W` = 8, and the copy-engine state enum.
- Sub-module `ddram_copy_buf`: MAX_BURST × 64 simple dual-port RAM with a registered write port and a combinational read port. It holds no state beyond the array.
- The FSM, counters and address registers stay in the top level.

## Test plan
- `len` = 0, `start` -> `done` at t+1, `aborted` = 0, no `rd_req`/`wr_req` ever.
- `src` = 0x100, `dst` = 0x200, `len` = 20, MAX_BURST = 8, read latency 5 -> three bursts of 8/8/4 at 0x100/0x108/0x110. 20 writes land at 0x200..0x213 with matching data, `words_done` = 20, then one `done` pulse.
- `rd_data_valid` coincident with `rd_ack`, plus random `wr_busy` and `wr_ack` delays of 0-7 cycles -> every request is held stable until its ack, there are no extra or missing beats, and destination data equals source data.
- `src` = 0x1FFFFFFE, `len` = 4 -> read burst wraps to 0x00000000/0x00000001 with no error, and 4 words are written.
- `abort` raised during the second burst's RD_DATA (`len` = 24) -> burst completes all 8 beats, no further `wr_req`, `done` with `aborted` = 1, `words_done` = 8.
- `reset_n` low during WR_REQ -> `wr_req`, `busy`, `words_done` = 0 at once. A new `start` after release runs a full job correctly.
